// File: rtl/oven_timer_digits.sv
// Oven cook-time entry and countdown engine: keypad MM:SS entry, once-per-second
// countdown while cooking, and blanked per-digit codes for the seven-segment decoders.
module oven_timer_digits #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TICK_W        = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       door_open,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       heating,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        COOK   = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]        BLANK     = 4'd11;

    state_t              cur, nxt;
    logic [3:0]          t3, t2, t1, t0;
    logic [3:0]          n3, n2, n1, n0;
    logic [TICK_W-1:0]   presc, presc_n;
    logic [15:0]         dec_t;
    logic                digit_ok, time_nz;
    logic                blank3, blank2, blank1;

    // One-second borrow chain: seconds-units, seconds-tens (wraps to 5), minutes.
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [3:0] a3, a2, a1, a0;
        {a3, a2, a1, a0} = t;
        if (a0 != 4'd0) begin
            a0 = a0 - 4'd1;
        end else begin
            a0 = 4'd9;
            if (a1 != 4'd0) begin
                a1 = a1 - 4'd1;
            end else begin
                a1 = 4'd5;
                if (a2 != 4'd0) begin
                    a2 = a2 - 4'd1;
                end else begin
                    a2 = 4'd9;
                    a3 = a3 - 4'd1;
                end
            end
        end
        return {a3, a2, a1, a0};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur   <= IDLE;
            t3    <= 4'd0;
            t2    <= 4'd0;
            t1    <= 4'd0;
            t0    <= 4'd0;
            presc <= '0;
        end else begin
            cur   <= nxt;
            t3    <= n3;
            t2    <= n2;
            t1    <= n1;
            t0    <= n0;
            presc <= presc_n;
        end
    end

    always_comb begin
        nxt              = cur;
        {n3, n2, n1, n0} = {t3, t2, t1, t0};
        presc_n          = presc;
        dec_t            = dec_time({t3, t2, t1, t0});
        digit_ok         = key_valid && (key_digit <= 4'd9);
        time_nz          = ({t3, t2, t1, t0} != 16'd0);

        if (clear) begin
            nxt              = IDLE;
            {n3, n2, n1, n0} = 16'd0;
            presc_n          = '0;
        end else begin
            case (cur)
                IDLE, ENTRY: begin
                    if (start && !door_open && time_nz && cur == ENTRY) begin
                        nxt     = COOK;
                        presc_n = '0;
                    end else if (!start && !pause && digit_ok) begin
                        {n3, n2, n1, n0} = {t2, t1, t0, key_digit};
                        nxt              = ENTRY;
                    end
                end
                COOK: begin
                    // Pausing holds the prescaler so the partial second is kept.
                    if (door_open || pause) begin
                        nxt = PAUSED;
                    end else if (presc == TICK_LAST) begin
                        presc_n          = '0;
                        {n3, n2, n1, n0} = dec_t;
                        if (dec_t == 16'd0) nxt = DONE;
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
                PAUSED: begin
                    if (start && !door_open) nxt = COOK;
                end
                DONE: begin
                    if (key_valid) begin
                        nxt     = IDLE;
                        presc_n = '0;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    // Leading-zero blanking ripples from the minutes-tens digit downward.
    always_comb begin
        blank3 = (t3 == 4'd0);
        blank2 = blank3 && (t2 == 4'd0);
        blank1 = blank2 && (t1 == 4'd0);
        dig3   = blank3 ? BLANK : t3;
        dig2   = blank2 ? BLANK : t2;
        dig1   = blank1 ? BLANK : t1;
        dig0   = t0;
    end

    assign heating = (cur == COOK);
    assign done    = (cur == DONE);
    assign state   = cur;

endmodule

// File: tb/tb_oven_timer_digits.sv
// Directed bench for oven_timer_digits: expected display/status pushed to a
// scoreboard before each stimulus step, popped and compared after it.
module tb_oven_timer_digits;

    localparam int         TPS = 4;
    localparam logic [3:0] B   = 4'd11;
    localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_COOK = 3'd2,
                           S_PAUSED = 3'd3, S_DONE = 3'd4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic       door_open = 1'b0;
    logic [3:0] dig3, dig2, dig1, dig0;
    logic       heating, done;
    logic [2:0] state;

    always #5 clk = ~clk;

    oven_timer_digits #(.TICKS_PER_SEC(TPS), .TICK_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .pause(pause), .clear(clear), .door_open(door_open),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
        .heating(heating), .done(done), .state(state)
    );

    typedef struct packed {
        logic [3:0] d3, d2, d1, d0;
        logic [2:0] st;
        logic       h, dn;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad = 0;

    function automatic exp_t mk(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                                input logic [3:0] d0, input logic [2:0] st, input logic h,
                                input logic dn);
        exp_t e;
        e.d3 = d3; e.d2 = d2; e.d1 = d1; e.d0 = d0; e.st = st; e.h = h; e.dn = dn;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  e;
        string tag;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        cmp({tag, ".dig3"},    {4'd0, dig3},    {4'd0, e.d3});
        cmp({tag, ".dig2"},    {4'd0, dig2},    {4'd0, e.d2});
        cmp({tag, ".dig1"},    {4'd0, dig1},    {4'd0, e.d1});
        cmp({tag, ".dig0"},    {4'd0, dig0},    {4'd0, e.d0});
        cmp({tag, ".state"},   {5'd0, state},   {5'd0, e.st});
        cmp({tag, ".heating"}, {7'd0, heating}, {7'd0, e.h});
        cmp({tag, ".done"},    {7'd0, done},    {7'd0, e.dn});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        push("reset", mk(B, B, B, 4'd0, S_IDLE, 1'b0, 1'b0));
        #12;
        pop_check();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        push("keys130", mk(B, 4'd1, 4'd3, 4'd0, S_ENTRY, 1'b0, 1'b0));
        key(4'd1); key(4'd3); key(4'd0);
        pop_check();

        push("clear_entry", mk(B, B, B, 4'd0, S_IDLE, 1'b0, 1'b0));
        do_clear();
        pop_check();

        push("key2", mk(B, B, B, 4'd2, S_ENTRY, 1'b0, 1'b0));
        key(4'd2);
        pop_check();
        push("start2", mk(B, B, B, 4'd2, S_COOK, 1'b1, 1'b0));
        do_start();
        pop_check();
        push("cook_1s", mk(B, B, B, 4'd1, S_COOK, 1'b1, 1'b0));
        tick(4);
        pop_check();
        push("cook_done", mk(B, B, B, 4'd0, S_DONE, 1'b0, 1'b1));
        tick(4);
        pop_check();
        push("done_start_ign", mk(B, B, B, 4'd0, S_DONE, 1'b0, 1'b1));
        do_start();
        pop_check();
        push("done_key_idle", mk(B, B, B, 4'd0, S_IDLE, 1'b0, 1'b0));
        key(4'd12);
        pop_check();

        push("keys1000", mk(4'd1, 4'd0, 4'd0, 4'd0, S_ENTRY, 1'b0, 1'b0));
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        pop_check();
        push("borrow_0959", mk(B, 4'd9, 4'd5, 4'd9, S_COOK, 1'b1, 1'b0));
        do_start();
        tick(4);
        pop_check();
        do_clear();

        key(4'd5);
        do_start();
        tick(2);
        push("door_pause", mk(B, B, B, 4'd5, S_PAUSED, 1'b0, 1'b0));
        door_open = 1'b1;
        tick(1);
        door_open = 1'b0;
        pop_check();
        push("pause_in_paused", mk(B, B, B, 4'd5, S_PAUSED, 1'b0, 1'b0));
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        pop_check();
        push("resume_retained", mk(B, B, B, 4'd4, S_COOK, 1'b1, 1'b0));
        do_start();
        tick(2);
        pop_check();
        do_clear();

        push("keys12345", mk(4'd2, 4'd3, 4'd4, 4'd5, S_ENTRY, 1'b0, 1'b0));
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        pop_check();
        push("key12_ign", mk(4'd2, 4'd3, 4'd4, 4'd5, S_ENTRY, 1'b0, 1'b0));
        key(4'd12);
        pop_check();
        push("start_door_open", mk(4'd2, 4'd3, 4'd4, 4'd5, S_ENTRY, 1'b0, 1'b0));
        door_open = 1'b1;
        do_start();
        door_open = 1'b0;
        pop_check();
        do_clear();

        push("start_zero_ign", mk(B, B, B, 4'd0, S_ENTRY, 1'b0, 1'b0));
        key(4'd0);
        do_start();
        pop_check();
        do_clear();

        push("entry_start_pause", mk(B, B, B, 4'd3, S_COOK, 1'b1, 1'b0));
        key(4'd3);
        start = 1'b1;
        pause = 1'b1;
        tick(1);
        pop_check();
        push("cook_start_pause", mk(B, B, B, 4'd3, S_PAUSED, 1'b0, 1'b0));
        tick(1);
        start = 1'b0;
        pause = 1'b0;
        pop_check();
        do_start();
        tick(1);
        push("clear_with_pause", mk(B, B, B, 4'd0, S_IDLE, 1'b0, 1'b0));
        clear = 1'b1;
        pause = 1'b1;
        tick(1);
        clear = 1'b0;
        pause = 1'b0;
        pop_check();

        key(4'd9);
        do_start();
        tick(2);
        push("async_reset", mk(B, B, B, 4'd0, S_IDLE, 1'b0, 1'b0));
        reset_n = 1'b0;
        #1;
        pop_check();
        tick(1);
        reset_n = 1'b1;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
